// File: rtl/sm_mem_arbiter.sv
// Round-robin arbiter that lets the fetch port and the data port share one
// synchronous single-port memory, using registered address and write controls.
module sm_mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iReq,
  input  logic [ADDR_WIDTH-1:0] iAddr,
  output logic                  iAck,
  output logic [DATA_WIDTH-1:0] iRData,
  input  logic                  dReq,
  input  logic                  dWe,
  input  logic [ADDR_WIDTH-1:0] dAddr,
  input  logic [DATA_WIDTH-1:0] dWData,
  output logic                  dAck,
  output logic [DATA_WIDTH-1:0] dRData,
  output logic [ADDR_WIDTH-1:0] mAddr,
  output logic                  mWe,
  output logic [DATA_WIDTH-1:0] mWData,
  input  logic [DATA_WIDTH-1:0] mRData,
  output logic                  busy
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic       OWN_I   = 1'b0;
  localparam logic       OWN_D   = 1'b1;
  localparam logic [3:0] LAT_CNT = 4'(MEM_LATENCY);

  state_t                state_r;
  state_t                state_s;
  logic                  owner_r;
  logic                  last_grant_r;
  logic [3:0]            cnt_r;
  logic [ADDR_WIDTH-1:0] maddr_r;
  logic                  mwe_r;
  logic [DATA_WIDTH-1:0] mwdata_r;
  logic                  grant_i_s;
  logic                  grant_d_s;
  logic                  ack_s;

  // Next-state logic: arbitration in IDLE and access completion in ACCESS.
  always_comb begin
    state_s   = state_r;
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    ack_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // On a conflict, the port that did not win last time gets the grant.
        if (dReq && (!iReq || (last_grant_r == OWN_I))) begin
          grant_d_s = 1'b1;
        end else if (iReq) begin
          grant_i_s = 1'b1;
        end else begin
          grant_d_s = 1'b0;
        end
        if (grant_i_s || grant_d_s) begin
          state_s = ST_ACCESS;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        // A write is done in its first cycle; a read waits for the latency count.
        if (mwe_r || (cnt_r == 4'd0)) begin
          ack_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ACCESS;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Capture the granted request and run the latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r      <= OWN_I;
      last_grant_r <= OWN_I;
      cnt_r        <= 4'd0;
      maddr_r      <= {ADDR_WIDTH{1'b0}};
      mwe_r        <= 1'b0;
      mwdata_r     <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (grant_i_s || grant_d_s) begin
            owner_r      <= grant_d_s;
            last_grant_r <= grant_d_s;
            maddr_r      <= grant_d_s ? dAddr : iAddr;
            mwe_r        <= grant_d_s & dWe;
            cnt_r        <= LAT_CNT;
            if (grant_d_s) begin
              mwdata_r <= dWData;
            end
          end
        end
        ST_ACCESS: begin
          mwe_r <= 1'b0;
          if (cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        default: begin
          mwe_r <= 1'b0;
        end
      endcase
    end
  end

  assign iAck   = ack_s && (owner_r == OWN_I);
  assign dAck   = ack_s && (owner_r == OWN_D);
  assign iRData = iAck ? mRData : {DATA_WIDTH{1'b0}};
  assign dRData = (dAck && !mwe_r) ? mRData : {DATA_WIDTH{1'b0}};
  assign mAddr  = maddr_r;
  assign mWe    = mwe_r;
  assign mWData = mwdata_r;
  assign busy   = (state_r == ST_ACCESS);

endmodule

// File: tb/tb_sm_mem_arbiter.sv
// Directed bench for sm_mem_arbiter: three instances (latency 1, 3, 2) share the
// requester inputs, and each one has its own registered-read memory model.
module tb_sm_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        iReq;
  logic [31:0] iAddr;
  logic        dReq;
  logic        dWe;
  logic [31:0] dAddr;
  logic [31:0] dWData;

  logic        iAck_a, dAck_a, mWe_a, busy_a;
  logic [31:0] iRData_a, dRData_a, mAddr_a, mWData_a, mRData_a;
  logic        iAck_b, dAck_b, mWe_b, busy_b;
  logic [31:0] iRData_b, dRData_b, mAddr_b, mWData_b, mRData_b;
  logic        iAck_c, dAck_c, mWe_c, busy_c;
  logic [31:0] iRData_c, dRData_c, mAddr_c, mWData_c, mRData_c;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] mem_c [256];
  bit          vld_a [256];
  bit          vld_b [256];
  bit          vld_c [256];

  int checks;
  int errors;

  sm_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .iReq(iReq), .iAddr(iAddr), .iAck(iAck_a), .iRData(iRData_a),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData), .dAck(dAck_a), .dRData(dRData_a),
    .mAddr(mAddr_a), .mWe(mWe_a), .mWData(mWData_a), .mRData(mRData_a), .busy(busy_a));

  sm_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .iReq(iReq), .iAddr(iAddr), .iAck(iAck_b), .iRData(iRData_b),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData), .dAck(dAck_b), .dRData(dRData_b),
    .mAddr(mAddr_b), .mWe(mWe_b), .mWData(mWData_b), .mRData(mRData_b), .busy(busy_b));

  sm_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .iReq(iReq), .iAddr(iAddr), .iAck(iAck_c), .iRData(iRData_c),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWData(dWData), .dAck(dAck_c), .dRData(dRData_c),
    .mAddr(mAddr_c), .mWe(mWe_c), .mWData(mWData_c), .mRData(mRData_c), .busy(busy_c));

  // Contents of a location that has never been written.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a[7:0] == 8'h10) return 32'hDEADBEEF;
    else return {24'hA5C3E1, a[7:0]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: write on the strobe, registered read one cycle after the address.
  always @(posedge clk) begin
    if (mWe_a) begin mem_a[mAddr_a[7:0]] <= mWData_a; vld_a[mAddr_a[7:0]] <= 1'b1; end
    mRData_a <= vld_a[mAddr_a[7:0]] ? mem_a[mAddr_a[7:0]] : init_word(mAddr_a);
  end
  always @(posedge clk) begin
    if (mWe_b) begin mem_b[mAddr_b[7:0]] <= mWData_b; vld_b[mAddr_b[7:0]] <= 1'b1; end
    mRData_b <= vld_b[mAddr_b[7:0]] ? mem_b[mAddr_b[7:0]] : init_word(mAddr_b);
  end
  always @(posedge clk) begin
    if (mWe_c) begin mem_c[mAddr_c[7:0]] <= mWData_c; vld_c[mAddr_c[7:0]] <= 1'b1; end
    mRData_c <= vld_c[mAddr_c[7:0]] ? mem_c[mAddr_c[7:0]] : init_word(mAddr_c);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    iReq = 1'b0;
    dReq = 1'b0;
    dWe  = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_a); end
    checks++; if (mAddr_a !== 32'h0) begin errors++; $display("FAIL rst_maddr: got %h expected 0", mAddr_a); end
    checks++; if (mWe_a !== 1'b0) begin errors++; $display("FAIL rst_mwe: got %b expected 0", mWe_a); end
    checks++; if (mWData_a !== 32'h0) begin errors++; $display("FAIL rst_mwdata: got %h expected 0", mWData_a); end
    checks++; if ({iAck_a, dAck_a} !== 2'b00) begin errors++; $display("FAIL rst_acks: got %b expected 00", {iAck_a, dAck_a}); end
    checks++; if ((iRData_a | dRData_a) !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h/%h expected 0", iRData_a, dRData_a); end
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fetch_read();
    iReq = 1'b1; iAddr = 32'h10;
    checks++; if (iAck_a !== 1'b0) begin errors++; $display("FAIL fetch_c0_ack: got %b expected 0", iAck_a); end
    step();
    checks++; if (mAddr_a !== 32'h10) begin errors++; $display("FAIL fetch_c1_maddr: got %h expected 10", mAddr_a); end
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL fetch_c1_busy: got %b expected 1", busy_a); end
    checks++; if (iAck_a !== 1'b0) begin errors++; $display("FAIL fetch_c1_ack: got %b expected 0", iAck_a); end
    step();
    checks++; if (iAck_a !== 1'b1) begin errors++; $display("FAIL fetch_c2_ack: got %b expected 1", iAck_a); end
    checks++; if (iRData_a !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_c2_data: got %h expected deadbeef", iRData_a); end
    checks++; if (dAck_a !== 1'b0) begin errors++; $display("FAIL fetch_c2_dack: got %b expected 0", dAck_a); end
    iReq = 1'b0;
    step();
    checks++; if ({iAck_a, busy_a} !== 2'b00) begin errors++; $display("FAIL fetch_c3_idle: got %b expected 00", {iAck_a, busy_a}); end
    idle_cycles(6);
  endtask

  task automatic test_write_then_read();
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h20; dWData = 32'h12345678;
    step();
    checks++; if (mWe_a !== 1'b1) begin errors++; $display("FAIL wr_c1_mwe: got %b expected 1", mWe_a); end
    checks++; if (mAddr_a !== 32'h20) begin errors++; $display("FAIL wr_c1_maddr: got %h expected 20", mAddr_a); end
    checks++; if (mWData_a !== 32'h12345678) begin errors++; $display("FAIL wr_c1_mwdata: got %h expected 12345678", mWData_a); end
    checks++; if (dAck_a !== 1'b1) begin errors++; $display("FAIL wr_c1_dack: got %b expected 1", dAck_a); end
    checks++; if (dRData_a !== 32'h0) begin errors++; $display("FAIL wr_c1_drdata: got %h expected 0", dRData_a); end
    dReq = 1'b0;
    step();
    checks++; if ({mWe_a, dAck_a, busy_a} !== 3'b000) begin errors++; $display("FAIL wr_c2_idle: got %b expected 000", {mWe_a, dAck_a, busy_a}); end
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h20;
    step();
    step();
    checks++; if (dAck_a !== 1'b1) begin errors++; $display("FAIL rdback_ack: got %b expected 1", dAck_a); end
    checks++; if (dRData_a !== 32'h12345678) begin errors++; $display("FAIL rdback_data: got %h expected 12345678", dRData_a); end
    idle_cycles(8);
  endtask

  task automatic test_round_robin();
    logic exp_i, exp_d;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    iReq = 1'b1; iAddr = 32'h30;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h40;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_d = (c == 2) || (c == 8);
      exp_i = (c == 5) || (c == 11);
      checks++; if (dAck_a !== exp_d) begin errors++; $display("FAIL rr_dack c%0d: got %b expected %b", c, dAck_a, exp_d); end
      checks++; if (iAck_a !== exp_i) begin errors++; $display("FAIL rr_iack c%0d: got %b expected %b", c, iAck_a, exp_i); end
      checks++; if (dRData_a !== (exp_d ? init_word(32'h40) : 32'h0)) begin errors++; $display("FAIL rr_drdata c%0d: got %h", c, dRData_a); end
      checks++; if (iRData_a !== (exp_i ? init_word(32'h30) : 32'h0)) begin errors++; $display("FAIL rr_irdata c%0d: got %h", c, iRData_a); end
      if (c == 11) begin
        iReq = 1'b0;
        dReq = 1'b0;
      end
    end
    idle_cycles(8);
  endtask

  task automatic test_latency3();
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h5;
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++; if (busy_b !== (c <= 4)) begin errors++; $display("FAIL lat3_busy c%0d: got %b", c, busy_b); end
      checks++; if (mAddr_b !== 32'h5) begin errors++; $display("FAIL lat3_maddr c%0d: got %h expected 5", c, mAddr_b); end
      checks++; if (dAck_b !== (c == 4)) begin errors++; $display("FAIL lat3_dack c%0d: got %b", c, dAck_b); end
      if (c == 4) begin
        checks++; if (dRData_b !== init_word(32'h5)) begin errors++; $display("FAIL lat3_data: got %h expected %h", dRData_b, init_word(32'h5)); end
        dReq = 1'b0;
      end
    end
    idle_cycles(8);
  endtask

  task automatic test_reset_mid_write();
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h50; dWData = 32'hCAFEF00D;
    step();
    checks++; if (mWe_a !== 1'b1) begin errors++; $display("FAIL rstw_pre_mwe: got %b expected 1", mWe_a); end
    rst_n = 1'b0;
    #1;
    checks++; if ({mWe_a, busy_a, dAck_a} !== 3'b000) begin errors++; $display("FAIL rstw_async: got %b expected 000", {mWe_a, busy_a, dAck_a}); end
    step();
    checks++; if (dAck_a !== 1'b0) begin errors++; $display("FAIL rstw_no_ack: got %b expected 0", dAck_a); end
    dWe = 1'b0; iReq = 1'b1; iAddr = 32'h70;
    rst_n = 1'b1;
    step();
    checks++; if (mAddr_a !== 32'h50) begin errors++; $display("FAIL rstw_d_first: got %h expected 50", mAddr_a); end
    step();
    checks++; if ({dAck_a, iAck_a} !== 2'b10) begin errors++; $display("FAIL rstw_acks: got %b expected 10", {dAck_a, iAck_a}); end
    checks++; if (dRData_a !== init_word(32'h50)) begin errors++; $display("FAIL rstw_aborted: got %h expected %h", dRData_a, init_word(32'h50)); end
    idle_cycles(8);
  endtask

  task automatic test_drop_mid_read();
    iReq = 1'b1; iAddr = 32'h60;
    step();
    checks++; if (busy_c !== 1'b1) begin errors++; $display("FAIL drop_c1_busy: got %b expected 1", busy_c); end
    iReq = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      step();
      checks++; if (iAck_c !== (c == 3)) begin errors++; $display("FAIL drop_iack c%0d: got %b", c, iAck_c); end
      checks++; if (busy_c !== (c == 2 || c == 3)) begin errors++; $display("FAIL drop_busy c%0d: got %b", c, busy_c); end
      if (c == 3) begin
        checks++; if (iRData_c !== init_word(32'h60)) begin errors++; $display("FAIL drop_data: got %h expected %h", iRData_c, init_word(32'h60)); end
      end
    end
    idle_cycles(4);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    iReq = 1'b0; iAddr = 32'h0;
    dReq = 1'b0; dWe = 1'b0; dAddr = 32'h0; dWData = 32'h0;
    test_reset();
    test_fetch_read();
    test_write_then_read();
    test_round_robin();
    test_latency3();
    test_reset_mid_write();
    test_drop_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_mem_arbiter.md
# sm_mem_arbiter

Two-port to one-port memory arbiter and access sequencer for the single-cycle CPU. It lets the instruction-fetch port and the data port share one synchronous single-port memory. Each requester uses a req/ack handshake, and the arbiter grants them round-robin. The arbiter drives the memory address, write enable and write data from registers, then returns read data with ack once the configured memory latency has elapsed. It sits between the CPU (with its stall logic) and the shared RAM.

## Interface
- ADDR_WIDTH, 32, word address width on all ports
- DATA_WIDTH, 32, data width on all ports
- MEM_LATENCY, 1, cycles from mAddr presented to mRData valid; legal range 1..15

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- iReq  in  1  fetch request; held with iAddr stable until iAck
- iAddr  in  ADDR_WIDTH  fetch word address
- iAck  out  1  one-cycle pulse; fetch complete, iRData valid
- iRData  out  DATA_WIDTH  mRData when iAck, else 0
- dReq  in  1  data request; held with dWe/dAddr/dWData stable until dAck
- dWe  in  1  1 = write, 0 = read
- dAddr  in  ADDR_WIDTH  data word address
- dWData  in  DATA_WIDTH  write data
- dAck  out  1  one-cycle pulse; data access complete
- dRData  out  DATA_WIDTH  mRData when dAck on a read, else 0
- mAddr  out  ADDR_WIDTH  memory address, registered
- mWe  out  1  memory write strobe, registered
- mWData  out  DATA_WIDTH  memory write data, registered
- mRData  in  DATA_WIDTH  memory read data
- busy  out  1  1 while in ACCESS

## Operation
- State machine:
  - IDLE: arbitrate. If any request is granted, go to ACCESS.
  - ACCESS: hold mAddr. If the access is a write, or cnt==0 on a read, pulse the owner's ack and go to IDLE.
- Arbitration happens only in IDLE:
  - If only one requester is requesting, it wins.
  - If both are requesting, the requester not recorded in lastGrant wins.
  - lastGrant updates on every grant and resets to I, so D wins the first conflict after reset.
- Capture on grant, at the edge leaving IDLE: owner, mAddr, mWe (1 only for a D write), mWData (dWData for D, else unchanged), cnt = MEM_LATENCY.
- In ACCESS, cnt decrements by 1 each cycle until it reaches 0. cnt is 4 bits wide and saturates at 0.
- mWe is high for exactly the first ACCESS cycle of a write. It is cleared at the edge leaving ACCESS.
- An ack is combinational from state, owner and cnt. Only the owner's ack asserts, and never both acks in the same cycle.
- Read data paths (iRData/dRData) are combinational from mRData, gated by their ack.
- A request dropped mid-access is a protocol violation. The access still completes, the ack still pulses, and there is no retry.
- A held request is re-arbitrated in the IDLE cycle after its ack. Each access therefore costs at least one IDLE cycle.
- A request raised during ACCESS waits; it is not pre-granted.

## Timing
- Reset values, applied immediately on asynchronous assertion: state IDLE, owner I, lastGrant I, cnt 0, mAddr 0, mWe 0, mWData 0. iAck, dAck and busy are 0, and iRData and dRData are 0.
- Reset asserted mid-access aborts the access. No ack is issued, and mWe drops without waiting for a clock edge.
- Timeline, with the request first sampled in IDLE at cycle 0:
  - Cycle 1: mAddr valid and busy=1.
  - Write: mWe=1 and ack=1 in cycle 1; IDLE again in cycle 2.
  - Read: ack in cycle 1+MEM_LATENCY with data = mRData; IDLE in cycle 2+MEM_LATENCY.
- Throughput: one write per 2 cycles; one read per MEM_LATENCY+2 cycles.
- Ack to the next grant of a held request: 1 cycle.
- mAddr stays stable from cycle 1 through the ack cycle, and holds its value in IDLE.

## Test plan
- MEM_LATENCY=1, mem[0x10]=0xDEADBEEF, iReq with iAddr=0x10 in cycle 0 -> mAddr=0x10 in cycle 1; iAck=1 and iRData=0xDEADBEEF in cycle 2 only; dAck stays 0.
- dReq, dWe=1, dAddr=0x20, dWData=0x12345678 -> mWe=1 with mAddr=0x20 and mWData=0x12345678 in cycle 1 only; dAck in cycle 1; a following D read of 0x20 returns 0x12345678.
- iReq and dReq both held from reset, both reads at distinct addresses -> grant order D, I, D, I; each ack arrives 3 cycles after the previous one; acks never overlap.
- MEM_LATENCY=3, D read of 0x5 -> busy=1 in cycles 1-4; mAddr=0x5 stable; dAck in cycle 4 only; IDLE in cycle 5.
- rst_n pulled low in cycle 1 of a D write -> mWe=0 and busy=0 immediately; no dAck. After release, with both requesters active, D is granted first.
- iReq dropped in cycle 1 of a MEM_LATENCY=2 read -> iAck still pulses in cycle 3; no further grant while both requests are low.
